// File: rtl/s526_misr_sa.sv
// s526_misr_sa: response compactor for the s526 benchmark.
// Folds the six s526 primary outputs into a 16-bit MISR under a
// start/skip/capture/done controller. Power-up cycles after START are
// discarded for SKIP_CYCLES edges, then CAPTURE_CYCLES samples are compacted.
// Optional feature macro: S526_MISR_GOLDEN_CMP_EN builds a registered
// SIGNATURE==GOLDEN comparator driving PASS; without it PASS is constant 0.
module s526_misr_sa #(
    parameter logic [15:0] SEED           = 16'h0000,
    parameter logic [15:0] POLY           = 16'h1021,
    parameter int          SKIP_CYCLES    = 8,
    parameter int          CAPTURE_CYCLES = 256,
    parameter logic [15:0] GOLDEN         = 16'h0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        START,
    input  logic [5:0]  RESP,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] SIGNATURE,
    output logic [15:0] SAMPLE_CNT,
    output logic        PASS
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SKIP    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // Terminal counts widened by one bit so the incremented counters can be
    // compared without wrap.
    localparam logic [8:0]  SKIP_LAST = 9'(SKIP_CYCLES);
    localparam logic [16:0] CAP_LAST  = 17'(CAPTURE_CYCLES);
    localparam logic        SKIP_NONE = (SKIP_CYCLES == 0);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_skip;
    logic [15:0] r_sig;
    logic [15:0] r_cnt;

    logic [8:0]  w_skip_inc;
    logic [16:0] w_cnt_inc;
    logic [15:0] w_misr_next;
    logic        w_load;
    logic        w_skip_en;
    logic        w_cap_en;
    logic        w_cap_last;

    assign w_skip_inc  = {1'b0, r_skip} + 9'd1;
    assign w_cnt_inc   = {1'b0, r_cnt} + 17'd1;
    assign w_cap_last  = (w_cnt_inc == CAP_LAST);
    assign w_misr_next = {r_sig[14:0], 1'b0}
                       ^ (r_sig[15] ? POLY : 16'h0000)
                       ^ {10'b0, RESP};

    // State register; reset dominates any START seen on the same edge.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: START only matters when no run is in flight.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    w_next = SKIP_NONE ? S_CAPTURE : S_SKIP;
                end
            end
            S_SKIP: begin
                if (w_skip_inc == SKIP_LAST) begin
                    w_next = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (w_cap_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output/control decode from the current state only (no RESP path).
    always_comb begin
        BUSY      = 1'b0;
        DONE      = 1'b0;
        w_load    = 1'b0;
        w_skip_en = 1'b0;
        w_cap_en  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = START;
            end
            S_SKIP: begin
                BUSY      = 1'b1;
                w_skip_en = 1'b1;
            end
            S_CAPTURE: begin
                BUSY     = 1'b1;
                w_cap_en = 1'b1;
            end
            S_DONE: begin
                DONE   = 1'b1;
                w_load = START;
            end
            default: ;
        endcase
    end

    // MISR, sample counter and skip counter; START reloads the seed.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_sig  <= SEED;
            r_cnt  <= 16'd0;
            r_skip <= 8'd0;
        end else if (w_load) begin
            r_sig  <= SEED;
            r_cnt  <= 16'd0;
            r_skip <= 8'd0;
        end else if (w_skip_en) begin
            r_skip <= w_skip_inc[7:0];
        end else if (w_cap_en) begin
            r_sig  <= w_misr_next;
            r_cnt  <= w_cnt_inc[15:0];
        end
    end

    assign SIGNATURE  = r_sig;
    assign SAMPLE_CNT = r_cnt;

`ifdef S526_MISR_GOLDEN_CMP_EN
    logic r_pass;

    // Compare the signature being written on the final capture edge so PASS
    // is valid in the same cycle DONE rises.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_pass <= 1'b0;
        end else if (w_load) begin
            r_pass <= 1'b0;
        end else if (w_cap_en && w_cap_last) begin
            r_pass <= (w_misr_next == GOLDEN);
        end
    end

    assign PASS = r_pass;
`else
    // No comparator: the AND with zero keeps GOLDEN referenced and folds away.
    assign PASS = 1'b0 & (^GOLDEN);
`endif

endmodule

// File: tb/tb_s526_misr_sa.sv
// Directed bench for s526_misr_sa: reset, impulse response, latency,
// retrigger/restart, mid-run reset and golden compare.
module tb_s526_misr_sa;

`ifdef S526_MISR_GOLDEN_CMP_EN
    localparam logic EXP_PASS_A = 1'b1;
`else
    localparam logic EXP_PASS_A = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // a/d: impulse config (GOLDEN match / mismatch), shared stimulus
    logic a_rst, a_start;
    logic [5:0] a_resp;
    logic a_busy, a_done, a_pass, d_busy, d_done, d_pass;
    logic [15:0] a_sig, a_cnt, d_sig, d_cnt;
    // b: latency config
    logic b_rst, b_start;
    logic [5:0] b_resp;
    logic b_busy, b_done, b_pass;
    logic [15:0] b_sig, b_cnt;
    // c: long run with non-zero seed
    logic c_rst, c_start;
    logic [5:0] c_resp;
    logic c_busy, c_done, c_pass;
    logic [15:0] c_sig, c_cnt;

    s526_misr_sa #(.SEED(16'h0000), .POLY(16'h1021), .SKIP_CYCLES(0),
                   .CAPTURE_CYCLES(17), .GOLDEN(16'h1021)) u_a (
        .CLOCK(clk), .RESET(a_rst), .START(a_start), .RESP(a_resp),
        .BUSY(a_busy), .DONE(a_done), .SIGNATURE(a_sig),
        .SAMPLE_CNT(a_cnt), .PASS(a_pass));

    s526_misr_sa #(.SEED(16'h0000), .POLY(16'h1021), .SKIP_CYCLES(0),
                   .CAPTURE_CYCLES(17), .GOLDEN(16'h1020)) u_d (
        .CLOCK(clk), .RESET(a_rst), .START(a_start), .RESP(a_resp),
        .BUSY(d_busy), .DONE(d_done), .SIGNATURE(d_sig),
        .SAMPLE_CNT(d_cnt), .PASS(d_pass));

    s526_misr_sa #(.SEED(16'h0000), .POLY(16'h1021), .SKIP_CYCLES(8),
                   .CAPTURE_CYCLES(4), .GOLDEN(16'h0000)) u_b (
        .CLOCK(clk), .RESET(b_rst), .START(b_start), .RESP(b_resp),
        .BUSY(b_busy), .DONE(b_done), .SIGNATURE(b_sig),
        .SAMPLE_CNT(b_cnt), .PASS(b_pass));

    s526_misr_sa #(.SEED(16'hACE1), .POLY(16'h1021), .SKIP_CYCLES(2),
                   .CAPTURE_CYCLES(256), .GOLDEN(16'h0000)) u_c (
        .CLOCK(clk), .RESET(c_rst), .START(c_start), .RESP(c_resp),
        .BUSY(c_busy), .DONE(c_done), .SIGNATURE(c_sig),
        .SAMPLE_CNT(c_cnt), .PASS(c_pass));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_rst = 1; b_rst = 1; c_rst = 1;
        a_start = 0; b_start = 0; c_start = 0;
        a_resp = 6'h3F; b_resp = 6'h3F; c_resp = 6'h3F;
        repeat (3) tick();
        a_rst = 0; b_rst = 0; c_rst = 0;
        checks++; if (a_sig !== 16'h0000) begin failures++; $display("FAIL reset_sig got=%h exp=0000", a_sig); end
        checks++; if (a_cnt !== 16'h0000) begin failures++; $display("FAIL reset_cnt got=%h exp=0000", a_cnt); end
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", a_busy, a_done); end
        checks++; if (a_pass !== 1'b0) begin failures++; $display("FAIL reset_pass got=%b exp=0", a_pass); end
        checks++; if (c_sig !== 16'hACE1) begin failures++; $display("FAIL reset_seed got=%h exp=ace1", c_sig); end
        repeat (4) tick();
        checks++; if (a_sig !== 16'h0000 || a_cnt !== 16'h0000 || a_busy !== 1'b0 || a_done !== 1'b0)
            begin failures++; $display("FAIL idle_hold sig=%h cnt=%h busy=%b done=%b exp 0000/0000/0/0", a_sig, a_cnt, a_busy, a_done); end
        checks++; if (b_sig !== 16'h0000 || b_busy !== 1'b0) begin failures++; $display("FAIL idle_hold_b sig=%h busy=%b exp 0000/0", b_sig, b_busy); end
    endtask

    task automatic test_impulse();
        a_start = 1; a_resp = 6'h00;
        tick();
        a_start = 0;
        checks++; if (a_busy !== 1'b1 || a_cnt !== 16'd0 || a_sig !== 16'h0000)
            begin failures++; $display("FAIL imp_start busy=%b cnt=%0d sig=%h exp 1/0/0000", a_busy, a_cnt, a_sig); end
        a_resp = 6'h01;
        tick();
        a_resp = 6'h00;
        checks++; if (a_sig !== 16'h0001 || a_cnt !== 16'd1) begin failures++; $display("FAIL imp_s1 sig=%h cnt=%0d exp 0001/1", a_sig, a_cnt); end
        repeat (15) tick();
        checks++; if (a_sig !== 16'h8000 || a_cnt !== 16'd16) begin failures++; $display("FAIL imp_s16 sig=%h cnt=%0d exp 8000/16", a_sig, a_cnt); end
        checks++; if (a_busy !== 1'b1 || a_done !== 1'b0) begin failures++; $display("FAIL imp_s16_busy got=%b%b exp=10", a_busy, a_done); end
        tick();
        checks++; if (a_sig !== 16'h1021 || a_cnt !== 16'd17) begin failures++; $display("FAIL imp_done sig=%h cnt=%0d exp 1021/17", a_sig, a_cnt); end
        checks++; if (a_busy !== 1'b0 || a_done !== 1'b1) begin failures++; $display("FAIL imp_done_flags busy=%b done=%b exp 0/1", a_busy, a_done); end
        checks++; if (a_pass !== EXP_PASS_A) begin failures++; $display("FAIL golden_match got=%b exp=%b", a_pass, EXP_PASS_A); end
        checks++; if (d_pass !== 1'b0 || d_sig !== 16'h1021) begin failures++; $display("FAIL golden_mismatch pass=%b sig=%h exp 0/1021", d_pass, d_sig); end
        a_resp = 6'h3F;
        repeat (3) tick();
        checks++; if (a_sig !== 16'h1021 || a_cnt !== 16'd17 || a_done !== 1'b1)
            begin failures++; $display("FAIL done_hold sig=%h cnt=%0d done=%b exp 1021/17/1", a_sig, a_cnt, a_done); end
        checks++; if (a_pass !== EXP_PASS_A) begin failures++; $display("FAIL pass_hold got=%b exp=%b", a_pass, EXP_PASS_A); end
        a_start = 1;
        tick();
        a_start = 0;
        checks++; if (a_pass !== 1'b0 || a_sig !== 16'h0000 || a_cnt !== 16'd0 || a_done !== 1'b0 || a_busy !== 1'b1)
            begin failures++; $display("FAIL imp_restart pass=%b sig=%h cnt=%0d done=%b busy=%b exp 0/0000/0/0/1", a_pass, a_sig, a_cnt, a_done, a_busy); end
    endtask

    task automatic test_latency();
        logic [5:0] cap_vals [4];
        cap_vals[0] = 6'h01; cap_vals[1] = 6'h00; cap_vals[2] = 6'h00; cap_vals[3] = 6'h3F;
        b_start = 1; b_resp = 6'h3F;
        tick();
        b_start = 0;
        checks++; if (b_busy !== 1'b1 || b_done !== 1'b0) begin failures++; $display("FAIL lat_k busy=%b done=%b exp 1/0", b_busy, b_done); end
        for (int j = 1; j <= 12; j++) begin
            b_resp = (j >= 9) ? cap_vals[j-9] : 6'h3F;
            tick();
            checks++;
            if (b_busy !== (j < 12) || b_done !== (j == 12)) begin
                failures++; $display("FAIL lat_edge%0d busy=%b done=%b exp %b/%b", j, b_busy, b_done, (j < 12), (j == 12));
            end
        end
        checks++; if (b_sig !== 16'h0037 || b_cnt !== 16'd4) begin failures++; $display("FAIL lat_sig sig=%h cnt=%0d exp 0037/4", b_sig, b_cnt); end
        b_resp = 6'h2A;
        repeat (3) tick();
        checks++; if (b_sig !== 16'h0037 || b_done !== 1'b1) begin failures++; $display("FAIL lat_hold sig=%h done=%b exp 0037/1", b_sig, b_done); end
    endtask

    task automatic test_retrigger();
        int n;
        c_start = 1; c_resp = 6'h00;
        tick();
        c_start = 0;
        repeat (2 + 10) tick();
        checks++; if (c_cnt !== 16'd10 || c_busy !== 1'b1) begin failures++; $display("FAIL retrig_pre cnt=%0d busy=%b exp 10/1", c_cnt, c_busy); end
        c_start = 1;
        tick();
        c_start = 0;
        checks++; if (c_cnt !== 16'd11) begin failures++; $display("FAIL retrig_ignored cnt=%0d exp 11", c_cnt); end
        n = 0;
        while (c_done !== 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (c_done !== 1'b1 || c_cnt !== 16'd256) begin failures++; $display("FAIL retrig_done done=%b cnt=%0d exp 1/256", c_done, c_cnt); end
        c_start = 1;
        tick();
        c_start = 0;
        checks++; if (c_sig !== 16'hACE1 || c_cnt !== 16'd0 || c_busy !== 1'b1 || c_done !== 1'b0)
            begin failures++; $display("FAIL restart sig=%h cnt=%0d busy=%b done=%b exp ace1/0/1/0", c_sig, c_cnt, c_busy, c_done); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        // continues the run restarted above (now at the first SKIP cycle)
        c_resp = 6'h2A;
        repeat (2 + 4) tick();
        checks++; if (c_cnt !== 16'd4 || c_busy !== 1'b1) begin failures++; $display("FAIL mid_pre cnt=%0d busy=%b exp 4/1", c_cnt, c_busy); end
        c_rst = 1; c_start = 1;
        tick();
        c_rst = 0; c_start = 0;
        checks++; if (c_sig !== 16'hACE1 || c_cnt !== 16'd0 || c_busy !== 1'b0 || c_done !== 1'b0)
            begin failures++; $display("FAIL mid_reset sig=%h cnt=%0d busy=%b done=%b exp ace1/0/0/0", c_sig, c_cnt, c_busy, c_done); end
        tick();
        checks++; if (c_busy !== 1'b0 || c_sig !== 16'hACE1) begin failures++; $display("FAIL mid_idle busy=%b sig=%h exp 0/ace1", c_busy, c_sig); end
        c_start = 1;
        tick();
        c_start = 0;
        n = 0;
        while (c_done !== 1'b1 && n < 400) begin tick(); n++; end
        checks++; if (n !== 258) begin failures++; $display("FAIL mid_rerun_len got=%0d exp=258", n); end
        checks++; if (c_done !== 1'b1 || c_cnt !== 16'd256 || c_busy !== 1'b0)
            begin failures++; $display("FAIL mid_rerun_done done=%b cnt=%0d busy=%b exp 1/256/0", c_done, c_cnt, c_busy); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_latency();
        test_retrigger();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
